// File: rtl/uart_tx_buffer_pkg.sv
// =============================================================================
// Module : uart_tx_buffer_pkg
// Brief  : Shared width, depth and launch-FSM state definitions for the
//          UART transmit buffer slice.
// Rev    : 1.0
// =============================================================================
`default_nettype none

package uart_tx_buffer_pkg;

  localparam int c_UART_DATA_W = 8;
  localparam int c_DEPTH_LOG2  = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } tx_state_t;

  function automatic int fifo_depth(input int depth_log2);
    return 1 << depth_log2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_buffer_fifo.sv
// =============================================================================
// Module : uart_sync_fifo
// Brief  : Synchronous byte FIFO with occupancy count and sticky overflow.
// Rev    : 1.0
// =============================================================================
`default_nettype none

module uart_sync_fifo
  import uart_tx_buffer_pkg::*;
#(
  parameter int DATA_W     = c_UART_DATA_W,
  parameter int DEPTH_LOG2 = c_DEPTH_LOG2
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  i_fWr,
  input  logic [DATA_W-1:0]     i_Data,
  input  logic                  i_fRd,
  input  logic                  i_fClrOvf,
  output logic [DATA_W-1:0]     o_Data,
  output logic                  o_fFull,
  output logic                  o_fEmpty,
  output logic [DEPTH_LOG2:0]   o_Count,
  output logic                  o_fOvf
);

  localparam int                c_DEPTH     = fifo_depth(DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0] c_DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [DATA_W-1:0]     r_mem [c_DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_ovf;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_rd;
  logic                  w_wr;

  assign w_full  = (r_count == c_DEPTH_CNT);
  assign w_empty = (r_count == '0);
  assign w_rd    = i_fRd && !w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_wr    = i_fWr && (!w_full || w_rd);

  always_ff @(posedge Clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_Data;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (i_fClrOvf) begin
        r_ovf <= 1'b0;
      end else if (i_fWr && !w_wr) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign o_Data   = r_mem[r_rd_ptr];
  assign o_fFull  = w_full;
  assign o_fEmpty = w_empty;
  assign o_Count  = r_count;
  assign o_fOvf   = r_ovf;

endmodule

`default_nettype wire

// File: rtl/uart_tx_buffer.sv
// =============================================================================
// Module : uart_tx_buffer
// Brief  : Byte FIFO plus launch FSM feeding UART_TX via fTx/fReady/fDone.
// Rev    : 1.0
// =============================================================================
`default_nettype none

module uart_tx_buffer
  import uart_tx_buffer_pkg::*;
#(
  parameter int DATA_W     = c_UART_DATA_W,
  parameter int DEPTH_LOG2 = c_DEPTH_LOG2
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  i_fWr,
  input  logic [DATA_W-1:0]     i_Data,
  input  logic                  i_fClrOvf,
  output logic                  o_fFull,
  output logic                  o_fEmpty,
  output logic [DEPTH_LOG2:0]   o_Count,
  output logic                  o_fOvf,
  output logic                  o_fTx,
  output logic [DATA_W-1:0]     o_TxData,
  input  logic                  i_TxReady,
  input  logic                  i_TxDone
);

  tx_state_t         r_state;
  tx_state_t         w_state_nxt;
  logic              w_pop;
  logic              w_empty;
  logic [DATA_W-1:0] w_head;
  logic              r_fTx;
  logic [DATA_W-1:0] r_TxData;

  uart_sync_fifo #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .Clk       (Clk),
    .Rst       (Rst),
    .i_fWr     (i_fWr),
    .i_Data    (i_Data),
    .i_fRd     (w_pop),
    .i_fClrOvf (i_fClrOvf),
    .o_Data    (w_head),
    .o_fFull   (o_fFull),
    .o_fEmpty  (w_empty),
    .o_Count   (o_Count),
    .o_fOvf    (o_fOvf)
  );

  // Done is only meaningful while waiting; ready is only meaningful while idle.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty && i_TxReady) begin
          w_pop       = 1'b1;
          w_state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (i_TxDone) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state  <= S_IDLE;
      r_fTx    <= 1'b0;
      r_TxData <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fTx   <= w_pop;
      if (w_pop) begin
        r_TxData <= w_head;
      end
    end
  end

  assign o_fEmpty = w_empty;
  assign o_fTx    = r_fTx;
  assign o_TxData = r_TxData;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_buffer.sv
// =============================================================================
// Module : tb_uart_tx_buffer
// Brief  : Self-checking bench: queue-based buffer model plus a behavioural
//          UART_TX/RX stand-in that records every byte it is handed.
// Rev    : 1.0
// =============================================================================
`default_nettype none

module tb_uart_tx_buffer;

  localparam int DEPTH = 16;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       fWr;
  logic [7:0] Data;
  logic       fClrOvf;
  logic       TxReady;
  logic       TxDone;
  logic       fFull;
  logic       fEmpty;
  logic [4:0] Count;
  logic       fOvf;
  logic       fTx;
  logic [7:0] TxData;

  int checks = 0;
  int errors = 0;

  // Reference model: buffer contents as a queue, plus the line's launch phase.
  logic [7:0] mq[$];
  logic       m_tx;
  logic [7:0] m_txd;
  logic       m_ovf;
  int         line_st;

  // Serial-side stand-in.
  logic       ubusy;
  int         ucnt;
  logic [7:0] ubyte;
  logic       gate;
  logic       rnd_gate;
  int         ulen;
  int         ntx;
  logic [7:0] rxq[$];
  logic [7:0] expq[$];

  uart_tx_buffer #(
    .DATA_W     (8),
    .DEPTH_LOG2 (4)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .i_fWr     (fWr),
    .i_Data    (Data),
    .i_fClrOvf (fClrOvf),
    .o_fFull   (fFull),
    .o_fEmpty  (fEmpty),
    .o_Count   (Count),
    .o_fOvf    (fOvf),
    .o_fTx     (fTx),
    .o_TxData  (TxData),
    .i_TxReady (TxReady),
    .i_TxDone  (TxDone)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_tx    = 1'b0;
    m_txd   = 8'h00;
    m_ovf   = 1'b0;
    line_st = 0;
  endtask

  task automatic model_step();
    logic pop;
    logic acc;
    if (!Rst) begin
      model_reset();
      return;
    end
    pop = (line_st == 0) && (mq.size() != 0) && TxReady;
    acc = fWr && ((mq.size() < DEPTH) || pop);
    m_tx = pop;
    if (pop) m_txd = mq.pop_front();
    if (acc) mq.push_back(Data);
    if (fClrOvf) m_ovf = 1'b0;
    else if (fWr && !acc) m_ovf = 1'b1;
    if (pop) line_st = 1;
    else if (line_st == 1) line_st = 2;
    else if (line_st == 2 && TxDone) line_st = 0;
  endtask

  task automatic check_all();
    chk("count", 32'(Count), 32'(mq.size()));
    chk("empty", 32'(fEmpty), 32'(mq.size() == 0));
    chk("full",  32'(fFull),  32'(mq.size() == DEPTH));
    chk("ovf",   32'(fOvf),   32'(m_ovf));
    chk("tx",    32'(fTx),    32'(m_tx));
    chk("txdata", 32'(TxData), 32'(m_txd));
  endtask

  task automatic uart_step();
    if (TxDone) TxDone = 1'b0;
    if (fTx) begin
      ubusy = 1'b1;
      ubyte = TxData;
      ucnt  = (ulen != 0) ? ulen : int'($urandom_range(1, 5));
      ntx++;
    end else if (ubusy) begin
      chk("txdata_stable", 32'(TxData), 32'(ubyte));
      ucnt--;
      if (ucnt == 0) begin
        TxDone = 1'b1;
        ubusy  = 1'b0;
        rxq.push_back(ubyte);
      end
    end
    if (rnd_gate) gate = 1'($urandom_range(0, 1));
    TxReady = !ubusy && gate;
  endtask

  task automatic cyc(input logic wr, input logic [7:0] d, input logic clr);
    fWr     = wr;
    Data    = d;
    fClrOvf = clr;
    @(posedge Clk);
    model_step();
    @(negedge Clk);
    check_all();
    uart_step();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    gate    = 1'b1;
    TxReady = !ubusy;
    while ((mq.size() != 0 || ubusy || line_st != 0) && n < 3000) begin
      cyc(1'b0, 8'h00, 1'b0);
      n++;
    end
    chk({tag, "_drain"}, 32'(n < 3000), 32'd1);
    repeat (2) cyc(1'b0, 8'h00, 1'b0);
  endtask

  task automatic cmp_rx(input string tag);
    chk({tag, "_rxlen"}, 32'(rxq.size()), 32'(expq.size()));
    for (int i = 0; i < rxq.size() && i < expq.size(); i++) begin
      chk({tag, "_rxbyte"}, 32'(rxq[i]), 32'(expq[i]));
    end
    rxq.delete();
    expq.delete();
  endtask

  initial begin
    logic [7:0] b;
    int         n;
    int         guard;
    logic       wr;

    Rst = 1'b0; fWr = 1'b0; Data = 8'h00; fClrOvf = 1'b0;
    TxReady = 1'b0; TxDone = 1'b0;
    gate = 1'b0; rnd_gate = 1'b0; ulen = 0; ubusy = 1'b0; ucnt = 0;
    ubyte = 8'h00; ntx = 0;
    model_reset();

    // Reset state
    repeat (3) cyc(1'b0, 8'h00, 1'b0);
    chk("rst_empty",  32'(fEmpty), 32'd1);
    chk("rst_full",   32'(fFull),  32'd0);
    chk("rst_count",  32'(Count),  32'd0);
    chk("rst_ovf",    32'(fOvf),   32'd0);
    chk("rst_tx",     32'(fTx),    32'd0);
    chk("rst_txdata", 32'(TxData), 32'd0);
    Rst = 1'b1;

    // Two back-to-back bytes, two-cycle launch latency
    gate = 1'b1; TxReady = 1'b1; ntx = 0;
    cyc(1'b1, 8'h3c, 1'b0);
    chk("lat_first_cycle", 32'(fTx), 32'd0);
    cyc(1'b1, 8'he5, 1'b0);
    chk("lat_launch", 32'(fTx), 32'd1);
    chk("lat_data",   32'(TxData), 32'h3c);
    expq.push_back(8'h3c); expq.push_back(8'he5);
    drain("pair");
    chk("pair_ntx", 32'(ntx), 32'd2);
    cmp_rx("pair");

    // Fill to full with the line stalled, then overflow
    gate = 1'b0; TxReady = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      expq.push_back(8'(i));
    end
    chk("fill_count", 32'(Count), 32'd16);
    chk("fill_full",  32'(fFull),  32'd1);
    cyc(1'b1, 8'hff, 1'b0);
    chk("ovf_set",   32'(fOvf),  32'd1);
    chk("ovf_count", 32'(Count), 32'd16);
    cyc(1'b0, 8'h00, 1'b1);
    chk("ovf_clr", 32'(fOvf), 32'd0);
    cyc(1'b1, 8'hee, 1'b1);
    chk("ovf_clr_wins", 32'(fOvf), 32'd0);

    // Write into a full FIFO on the same cycle as a pop
    gate = 1'b1; TxReady = 1'b1;
    cyc(1'b1, 8'haa, 1'b0);
    chk("popwr_count", 32'(Count), 32'd16);
    chk("popwr_ovf",   32'(fOvf),  32'd0);
    chk("popwr_tx",    32'(fTx),   32'd1);
    expq.push_back(8'haa);
    drain("full");
    cmp_rx("full");

    // Asynchronous reset while a transfer is in flight
    ulen = 8; gate = 1'b1; TxReady = !ubusy;
    for (int i = 0; i < 6; i++) cyc(1'b1, 8'h80 | 8'($urandom_range(0, 127)), 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("midrst_queued", 32'(Count), 32'd5);
    #2 Rst = 1'b0;
    model_reset();
    #1;
    chk("midrst_tx",     32'(fTx),    32'd0);
    chk("midrst_count",  32'(Count),  32'd0);
    chk("midrst_empty",  32'(fEmpty), 32'd1);
    chk("midrst_txdata", 32'(TxData), 32'd0);
    ubusy = 1'b0; ucnt = 0; TxDone = 1'b0; TxReady = 1'b0; ulen = 0;
    rxq.delete(); expq.delete();
    repeat (2) cyc(1'b0, 8'h00, 1'b0);
    Rst = 1'b1; gate = 1'b1; TxReady = 1'b1; ntx = 0;
    repeat (10) cyc(1'b0, 8'h00, 1'b0);
    chk("postrst_no_tx", 32'(ntx), 32'd0);
    cyc(1'b1, 8'h5a, 1'b0);
    expq.push_back(8'h5a);
    drain("postrst");
    chk("postrst_ntx", 32'(ntx), 32'd1);
    cmp_rx("postrst");

    // Randomised stream with toggling ready; pointers wrap several times
    rnd_gate = 1'b1;
    n = 0; guard = 0;
    while (n < 40 && guard < 5000) begin
      wr = (mq.size() < DEPTH) && ($urandom_range(0, 3) != 0);
      b  = 8'(n);
      cyc(wr, b, 1'($urandom_range(0, 7) == 0));
      if (wr) begin
        expq.push_back(b);
        n++;
      end
      guard++;
    end
    chk("stream_issued", 32'(n), 32'd40);
    rnd_gate = 1'b0;
    drain("stream");
    cmp_rx("stream");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
